// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds down-counter for the digital clock.
// A preset is loaded and clamped to MAX_MIN:59. While running, the count
// decrements once per second. When the seconds underflow, one minute is
// borrowed. Reaching 00:00 gives a one-cycle done pulse and enters EXPIRED.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined, the
// count reloads the saved preset on the cycle after 00:00 and keeps running.
// In that build EXPIRED is never entered and expired is tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load, min_in,     load request with the preset value (binary)
//   sec_in
//   start, stop       resume / pause requests (priority load > stop > start)
//   min_out, sec_out  current count, registered
//   running, expired  decoded from the registered state
//   done              one-cycle pulse, coincident with the outputs at 00:00
module countdown_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int MAX_MIN  = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int         PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0] MAX_M  = 7'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] psc;
  logic [6:0]    min_cl;
  logic [5:0]    sec_cl;
  logic          nonzero;
  logic          tick;
  logic          reload;
  logic [6:0]    rl_min;
  logic [5:0]    rl_sec;

  always_comb begin
    min_cl = (min_in > MAX_M)  ? MAX_M : min_in;
    sec_cl = (sec_in > 6'd59) ? 6'd59 : sec_in;
  end

  assign nonzero = (min_out != 7'd0) || (sec_out != 6'd0);
  assign tick    = (psc == PS_MAX);
  assign running = (state == RUN);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [6:0] preset_min;
  logic [5:0] preset_sec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preset_min <= '0;
      preset_sec <= '0;
    end else if (load && state != RUN) begin
      preset_min <= min_cl;
      preset_sec <= sec_cl;
    end
  end

  // A 00:00 value can only be seen in RUN on the cycle right after the done
  // pulse. That cycle performs the reload.
  assign reload  = !nonzero;
  assign rl_min  = preset_min;
  assign rl_sec  = preset_sec;
  assign expired = 1'b0;
`else
  assign reload  = 1'b0;
  assign rl_min  = '0;
  assign rl_sec  = '0;
  assign expired = (state == EXPIRED);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      min_out <= '0;
      sec_out <= '0;
      psc     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        if (reload) begin
          min_out <= rl_min;
          sec_out <= rl_sec;
        end
        if (stop) begin
          // Hold the prescaler so that resuming finishes the partial second.
          state <= PAUSE;
        end else begin
          // The prescaler keeps counting through the reload cycle. This
          // makes the auto-reload period an exact multiple of TICK_DIV.
          psc <= tick ? '0 : psc + 1'b1;
          if (tick && !reload) begin
            if (sec_out != 6'd0) begin
              sec_out <= sec_out - 1'b1;
              if (min_out == 7'd0 && sec_out == 6'd1) begin
                done <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                state <= EXPIRED;
`endif
              end
            end else if (min_out != 7'd0) begin
              min_out <= min_out - 1'b1;
              sec_out <= 6'd59;
            end
          end
        end
      end else if (load) begin
        min_out <= min_cl;
        sec_out <= sec_cl;
        psc     <= '0;
        state   <= IDLE;
      end else if (start && nonzero && state != EXPIRED) begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [6:0] min_in = '0;
  logic [5:0] sec_in = '0;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running, expired, done;

  countdown_timer #(.TICK_DIV(4), .MAX_MIN(99)) dut (
    .clk(clk), .rst(rst), .load(load), .min_in(min_in), .sec_in(sec_in),
    .start(start), .stop(stop), .min_out(min_out), .sec_out(sec_out),
    .running(running), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [6:0] mi;
    logic [5:0] si;
    logic       st;
    logic       sp;
    int         n;
    logic [6:0] em;
    logic [5:0] es;
    logic       er;
    logic       ee;
    logic       ed;
  } vec_t;

  typedef struct {
    int         row;
    logic [6:0] em;
    logic [5:0] es;
    logic       er;
    logic       ee;
    logic       ed;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic ld, logic [6:0] mi, logic [5:0] si,
                              logic st, logic sp, int n, logic [6:0] em,
                              logic [5:0] es, logic er, logic ee, logic ed);
    vec_t v;
    v.ld = ld; v.mi = mi; v.si = si; v.st = st; v.sp = sp; v.n = n;
    v.em = em; v.es = es; v.er = er; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string nm, int row, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic check_outputs(int row, exp_t e);
    chk("min_out", row, int'(min_out), int'(e.em));
    chk("sec_out", row, int'(sec_out), int'(e.es));
    chk("running", row, int'(running), int'(e.er));
    chk("expired", row, int'(expired), int'(e.ee));
    chk("done",    row, int'(done),    int'(e.ed));
  endtask

  // Each vector drives its inputs for n cycles. For every cycle, the
  // expectation is queued at the drive and popped after the edge.
  task automatic apply(int row, vec_t v);
    exp_t e;
    for (int k = 0; k < v.n; k++) begin
      @(negedge clk);
      load = v.ld; min_in = v.mi; sec_in = v.si; start = v.st; stop = v.sp;
      e.row = row; e.em = v.em; e.es = v.es; e.er = v.er; e.ee = v.ee; e.ed = v.ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
      end else begin
        e = sb.pop_front();
        check_outputs(e.row, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    // A: load 00:03 and run until expiry
    vq.push_back(mk(1, 0, 3, 0, 0, 1,   0, 3, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   0, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,   0, 3, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,   0, 2, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,   0, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 2,   0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0));
    // B: borrow 02:00 -> 01:59, load ignored in RUN, then pause
    vq.push_back(mk(1, 2, 0, 0, 0, 1,   2, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   2, 0, 1, 0, 0));
    vq.push_back(mk(1, 3, 3, 0, 0, 1,   2, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,   2, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   1, 59, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 3,   1, 59, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   1, 58, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1,   1, 58, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,   1, 58, 0, 0, 0));
    // C: clamping and load+start priority
    vq.push_back(mk(1, 120, 63, 0, 0, 1, 99, 59, 0, 0, 0));
    vq.push_back(mk(1, 98, 58, 0, 0, 1,  98, 58, 0, 0, 0));
    vq.push_back(mk(1, 100, 60, 0, 0, 1, 99, 59, 0, 0, 0));
    vq.push_back(mk(1, 120, 63, 1, 0, 1, 99, 59, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,    99, 59, 0, 0, 0));
    // D: pause mid-second keeps the prescaler, stop+start -> PAUSE
    vq.push_back(mk(1, 0, 10, 0, 0, 1,  0, 10, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   0, 10, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,   0, 10, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 1,   0, 10, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 20,  0, 10, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   0, 10, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 10, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1,   0, 9, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 1, 1,   0, 9, 0, 0, 0));
    // E: start on 00:00 is ignored
    vq.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0));
    // F: run from 05:30, then reset asynchronously below
    vq.push_back(mk(1, 5, 30, 0, 0, 1,  5, 30, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 0, 1,   5, 30, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 2,   5, 30, 1, 0, 0));

    // Reset state, sampled while rst is held
    #3;
    r.em = 0; r.es = 0; r.er = 0; r.ee = 0; r.ed = 0;
    check_outputs(-1, r);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) apply(i, vq[i]);

    // Asynchronous reset mid-RUN, checked before any clock edge
    @(negedge clk);
    load = 0; start = 0; stop = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    r.em = 0; r.es = 0; r.er = 0; r.ee = 0; r.ed = 0;
    check_outputs(-2, r);
    @(negedge clk);
    rst = 1'b0;
    apply(-3, mk(0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
    chk("sb_empty", -4, sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
